// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared types, widths and GF(2^8) helpers for the AES inverse
//               cipher datapath.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int NR_DEFAULT = 10;
    localparam int BLOCK_W    = 128;
    localparam int KEY_IDX_W  = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_KEY = 3'd1,
        PREFETCH = 3'd2,
        ADDKEY   = 3'd3,
        ROUND    = 3'd4,
        FINAL    = 3'd5,
        DONE     = 3'd6
    } state_e;

    // Entry 0x00 sits in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return 8'(INV_SBOX >> (11'd2040 - {x, 3'b000}));
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant; only 0x9/0xb/0xd/0xe are used.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? x : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_round.sv
// ============================================================================
// Module      : aes_inv_round
// Description : Combinational AES inverse round: InvShiftRows, InvSubBytes,
//               AddRoundKey, then InvMixColumns unless skip_mix is set.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module aes_inv_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_state,
    input  logic [BLOCK_W-1:0] i_round_key,
    input  logic               skip_mix,
    output logic [BLOCK_W-1:0] o_state
);

    logic [7:0] w_ak [16];
    logic [7:0] w_mc [16];

    // Byte b is row b%4, column b/4; row r rotates right by r columns.
    for (genvar b = 0; b < 16; b++) begin : g_byte
        localparam int ROW = b % 4;
        localparam int COL = b / 4;
        localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
        assign w_ak[b] = inv_sbox(i_state[127-8*SRC -: 8]) ^ i_round_key[127-8*b -: 8];
        assign o_state[127-8*b -: 8] = skip_mix ? w_ak[b] : w_mc[b];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_mc[4*c+r] = gf_mul(w_ak[4*c + r],           4'he) ^
                                 gf_mul(w_ak[4*c + ((r+1) % 4)], 4'hb) ^
                                 gf_mul(w_ak[4*c + ((r+2) % 4)], 4'hd) ^
                                 gf_mul(w_ak[4*c + ((r+3) % 4)], 4'h9);
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_inv_cipher.sv
// ============================================================================
// Module      : aes_inv_cipher
// Description : Iterative AES-128 inverse cipher, one round per clock, with
//               round keys fetched from an external key store.
//               Define AES_INV_CIPHER_ZEROIZE_EN to clear the result and the
//               state register on the cycle after valid.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module aes_inv_cipher
    import aes_pkg::*;
#(
    parameter int NR = NR_DEFAULT
)(
    input  logic                 clk,
    input  logic                 rest,
    input  logic                 start,
    input  logic [BLOCK_W-1:0]   cipher_in,
    input  logic                 key_done,
    input  logic [BLOCK_W-1:0]   key_round,
    output logic [KEY_IDX_W-1:0] round_no,
    output logic [BLOCK_W-1:0]   plain_out,
    output logic                 valid,
    output logic                 busy
);

    localparam logic [KEY_IDX_W-1:0] NR_IDX = KEY_IDX_W'(NR);

    state_e               state_q, state_d;
    logic [BLOCK_W-1:0]   data_q,  data_d;
    logic [BLOCK_W-1:0]   plain_q, plain_d;
    logic [KEY_IDX_W-1:0] round_q, round_d;
    logic [KEY_IDX_W-1:0] w_round_dec;
    logic [BLOCK_W-1:0]   w_round_out;

    aes_inv_round u_round (
        .i_state     (data_q),
        .i_round_key (key_round),
        .skip_mix    (state_q == FINAL),
        .o_state     (w_round_out)
    );

    assign w_round_dec = (round_q != '0) ? round_q - 4'd1 : '0;

    // round_no runs one cycle ahead of the key it selects, since the key
    // store answers a cycle later.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        plain_d = plain_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d = cipher_in;
                    if (key_done) begin
                        state_d = PREFETCH;
                        round_d = NR_IDX;
                    end else begin
                        state_d = WAIT_KEY;
                    end
                end
            end
            WAIT_KEY: begin
                if (key_done) begin
                    state_d = PREFETCH;
                    round_d = NR_IDX;
                end
            end
            PREFETCH: begin
                state_d = ADDKEY;
                round_d = w_round_dec;
            end
            ADDKEY: begin
                data_d  = data_q ^ key_round;
                state_d = ROUND;
                round_d = w_round_dec;
            end
            ROUND: begin
                data_d  = w_round_out;
                round_d = w_round_dec;
                if (round_q == '0) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                data_d  = w_round_out;
                plain_d = w_round_out;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
`ifdef AES_INV_CIPHER_ZEROIZE_EN
                data_d  = '0;
                plain_d = '0;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Losing the key store mid-operation abandons the block silently.
        if (!key_done && (state_q inside {PREFETCH, ADDKEY, ROUND, FINAL})) begin
            state_d = IDLE;
            round_d = '0;
            data_d  = data_q;
            plain_d = plain_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q <= IDLE;
            data_q  <= '0;
            plain_q <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            plain_q <= plain_d;
            round_q <= round_d;
        end
    end

    assign round_no  = round_q;
    assign plain_out = plain_q;
    assign valid     = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire
